// File: rtl/pattern_sweep_gen_if.sv
// Controller/DUT-side bundle for pattern_sweep_gen.
// The master drives start/abort/mode/dut_out; the slave (the generator) drives the sweep outputs.
interface pattern_sweep_gen_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic             dut_out;
    logic [WIDTH-1:0] pattern;
    logic             valid;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   vec_index;
    logic [WIDTH:0]   ones_count;
    logic [1:0]       dbg_state;

    modport master (
        output start, abort, mode, dut_out,
        input  pattern, valid, busy, done, vec_index, ones_count, dbg_state
    );

    modport slave (
        input  start, abort, mode, dut_out,
        output pattern, valid, busy, done, vec_index, ones_count, dbg_state
    );
endinterface

// File: rtl/pattern_sweep_gen.sv
// Exhaustive/walking stimulus generator: steps through every vector of the chosen mode, holding each
// for DWELL cycles, then pulses done. Define SWEEP_CAPTURE_EN to count dut_out=1 samples in ones_count.
module pattern_sweep_gen #(
    parameter int WIDTH = 5,
    parameter int DWELL = 20
) (
    input  logic                clk,
    input  logic                rst,
    pattern_sweep_gen_if.slave  bus
);
    localparam int IW = WIDTH + 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [IW-1:0] LAST_BIN   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [IW-1:0] LAST_WALK  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [DW-1:0]    dwell_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] pattern_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             dwell_end;
    logic             last_vec;
    logic [IW-1:0]    idx_d;

    function automatic logic [WIDTH-1:0] vec_of(input logic [1:0] m, input logic [IW-1:0] i);
        logic [WIDTH-1:0] one_hot;
        one_hot = WIDTH'(1) << i;
        case (m)
            2'b00:   vec_of = i[WIDTH-1:0];
            2'b01:   vec_of = i[WIDTH-1:0] ^ i[WIDTH:1];
            2'b10:   vec_of = one_hot;
            default: vec_of = ~one_hot;
        endcase
    endfunction

    always_comb begin
        dwell_end = (dwell_q == DWELL_LAST);
        last_vec  = (idx_q == (mode_q[1] ? LAST_WALK : LAST_BIN));
        idx_d     = idx_q + 1'b1;
    end

    // valid marks a live sweep vector; the DUT side has no backpressure, so valid is never stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'b00;
            dwell_q   <= '0;
            idx_q     <= '0;
            pattern_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_RUN;
                        mode_q    <= bus.mode;
                        dwell_q   <= '0;
                        idx_q     <= '0;
                        pattern_q <= vec_of(bus.mode, '0);
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state_q   <= S_IDLE;
                        dwell_q   <= '0;
                        idx_q     <= '0;
                        pattern_q <= '0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (dwell_end) begin
                        dwell_q <= '0;
                        idx_q   <= idx_d;
                        if (last_vec) begin
                            // idx_q lands on N here, which is what vec_index shows during DONE.
                            state_q   <= S_DONE;
                            pattern_q <= '0;
                            valid_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            pattern_q <= vec_of(mode_q, idx_d);
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pattern   = pattern_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.vec_index = idx_q;
    assign bus.dbg_state = state_q;

`ifdef SWEEP_CAPTURE_EN
    logic [IW-1:0] ones_q;

    // Sample on the final dwell cycle so the DUT has had the whole dwell to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            ones_q <= '0;
        end else if (state_q == S_RUN && dwell_end && bus.dut_out && ones_q != '1) begin
            ones_q <= ones_q + 1'b1;
        end
    end

    assign bus.ones_count = ones_q;
`else
    logic unused_dut_out;
    assign unused_dut_out = bus.dut_out;
    assign bus.ones_count = '0;
`endif
endmodule
